// File: rtl/vpu_operand_fetch.sv
// Operand fetch: decodes one VPU instruction, reads its sources from the SRAM banks, emits an operand bundle.
// Optional: VPU_OPFETCH_SAME_ADDR_MERGE_EN lets sources with identical bank and row share one read.
module vpu_operand_fetch #(
    parameter int unsigned SRAM_BANK_CNT       = 4,
    parameter int unsigned SRAM_BANK_DEPTH_LG2 = 10,
    parameter int unsigned SRAM_DATA_WIDTH     = 512,
    parameter int unsigned SRC_OPERAND_CNT     = 3,
    parameter int unsigned RD_LAT              = 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           instr_valid_i,
    output logic                                           instr_ready_o,
    input  logic [135:0]                                   instr_i,
    output logic [SRAM_BANK_CNT-1:0]                       bank_rd_en_o,
    output logic [SRAM_BANK_CNT*SRAM_BANK_DEPTH_LG2-1:0]   bank_raddr_o,
    input  logic [SRAM_BANK_CNT*SRAM_DATA_WIDTH-1:0]       bank_rdata_i,
    output logic                                           op_valid_o,
    input  logic                                           op_ready_i,
    output logic [7:0]                                     op_opcode_o,
    output logic [31:0]                                    op_dst_o,
    output logic [1:0]                                     op_src_cnt_o,
    output logic [SRC_OPERAND_CNT*SRAM_DATA_WIDTH-1:0]     op_src_data_o,
    output logic                                           err_illegal_op_o,
    output logic                                           err_addr_o
);
    localparam int unsigned BANK_W  = $clog2(SRAM_BANK_CNT);
    localparam int unsigned ROW_LSB = 9 + BANK_W;
    localparam int unsigned HI_LSB  = ROW_LSB + SRAM_BANK_DEPTH_LG2;
    localparam int unsigned DW      = SRAM_DATA_WIDTH;
    localparam int unsigned RW      = SRAM_BANK_DEPTH_LG2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t                                 r_state, w_state_nxt;
    logic [7:0]                             r_opcode;
    logic [31:0]                            r_dst;
    logic [1:0]                             r_src_cnt;
    logic [BANK_W-1:0]                      r_bank [SRC_OPERAND_CNT];
    logic [RW-1:0]                          r_row  [SRC_OPERAND_CNT];
    logic [DW-1:0]                          r_data [SRC_OPERAND_CNT];
    logic [SRC_OPERAND_CNT-1:0]             r_pending, r_issued;
    logic [2:0]                             r_wait_cnt;
    logic [SRAM_BANK_CNT*RW-1:0]            r_raddr;
    logic                                   r_err_ill, r_err_addr;

    logic [7:0]                             w_op;
    logic [31:0]                            w_src [SRC_OPERAND_CNT];
    logic                                   w_legal, w_one_src, w_addr_bad, w_accept, w_take, w_out;
    logic [SRC_OPERAND_CNT-1:0]             w_used, w_issue;
    logic [SRAM_BANK_CNT-1:0]               w_rd_en;
    logic [SRAM_BANK_CNT*RW-1:0]            w_raddr;

    always_comb begin
        w_op       = instr_i[135:128];
        w_legal    = (w_op >= 8'h01) && (w_op <= 8'h0E);
        w_one_src  = (w_op == 8'h05) || (w_op == 8'h0C) || (w_op == 8'h0D);
        w_addr_bad = 1'b0;
        for (int unsigned s = 0; s < SRC_OPERAND_CNT; s++) begin
            w_src[s]  = instr_i[32*(s+1) +: 32];
            w_used[s] = (s == 0) || ((s == 1) && !w_one_src);
            if (w_used[s] && (|w_src[s][31:HI_LSB]))
                w_addr_bad = 1'b1;
        end
        w_accept = instr_valid_i && (r_state == S_IDLE);
        w_take   = w_accept && w_legal && !w_addr_bad;
        w_out    = (r_state == S_OUT);
    end

    // Lowest pending slot claims its bank; later slots on the same bank wait for another round.
    always_comb begin
        w_rd_en = '0;
        w_raddr = r_raddr;
        w_issue = '0;
        if (r_state == S_ISSUE) begin
            for (int unsigned s = 0; s < SRC_OPERAND_CNT; s++) begin
                if (r_pending[s]) begin
                    if (!w_rd_en[r_bank[s]]) begin
                        w_rd_en[r_bank[s]]               = 1'b1;
                        w_raddr[r_bank[s]*RW +: RW]      = r_row[s];
                        w_issue[s]                       = 1'b1;
                    end
`ifdef VPU_OPFETCH_SAME_ADDR_MERGE_EN
                    else if (w_raddr[r_bank[s]*RW +: RW] == r_row[s]) begin
                        w_issue[s] = 1'b1;
                    end
`endif
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (r_wait_cnt == 3'd1) w_state_nxt = (|r_pending) ? S_ISSUE : S_OUT;
            S_OUT:   if (op_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_opcode   <= '0;
            r_dst      <= '0;
            r_src_cnt  <= '0;
            r_pending  <= '0;
            r_issued   <= '0;
            r_wait_cnt <= '0;
            r_raddr    <= '0;
            r_err_ill  <= 1'b0;
            r_err_addr <= 1'b0;
            for (int unsigned s = 0; s < SRC_OPERAND_CNT; s++) begin
                r_bank[s] <= '0;
                r_row[s]  <= '0;
                r_data[s] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_raddr    <= w_raddr;
            r_err_ill  <= w_accept && !w_legal;
            r_err_addr <= w_accept && w_legal && w_addr_bad;
            case (r_state)
                S_IDLE: if (w_take) begin
                    r_opcode  <= w_op;
                    r_dst     <= instr_i[31:0];
                    r_src_cnt <= w_one_src ? 2'd1 : 2'd2;
                    r_pending <= w_used;
                    for (int unsigned s = 0; s < SRC_OPERAND_CNT; s++) begin
                        r_bank[s] <= w_src[s][9 +: BANK_W];
                        r_row[s]  <= w_src[s][ROW_LSB +: RW];
                    end
                end
                S_ISSUE: begin
                    r_pending  <= r_pending & ~w_issue;
                    r_issued   <= w_issue;
                    r_wait_cnt <= 3'(RD_LAT);
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 3'd1;
                    if (r_wait_cnt == 3'd1) begin
                        for (int unsigned s = 0; s < SRC_OPERAND_CNT; s++)
                            if (r_issued[s])
                                r_data[s] <= bank_rdata_i[r_bank[s]*DW +: DW];
                    end
                end
                S_OUT: if (op_ready_i) begin
                    r_opcode  <= '0;
                    r_dst     <= '0;
                    r_src_cnt <= '0;
                    for (int unsigned s = 0; s < SRC_OPERAND_CNT; s++)
                        r_data[s] <= '0;
                end
                default: ;
            endcase
        end
    end

    // Payload is only visible while the bundle is offered.
    always_comb begin
        instr_ready_o    = (r_state == S_IDLE);
        bank_rd_en_o     = w_rd_en;
        bank_raddr_o     = w_raddr;
        op_valid_o       = w_out;
        op_opcode_o      = w_out ? r_opcode : '0;
        op_dst_o         = w_out ? r_dst : '0;
        op_src_cnt_o     = w_out ? r_src_cnt : '0;
        err_illegal_op_o = r_err_ill;
        err_addr_o       = r_err_addr;
        op_src_data_o    = '0;
        for (int unsigned s = 0; s < SRC_OPERAND_CNT; s++)
            op_src_data_o[s*DW +: DW] = w_out ? r_data[s] : '0;
    end
endmodule

// File: tb/tb_vpu_operand_fetch.sv
// Scoreboard bench for vpu_operand_fetch with a one-cycle-latency SRAM bank model.
module tb_vpu_operand_fetch;
    localparam int DW = 512;
    localparam int NB = 4;
    localparam int RL = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              instr_valid_i;
    logic              instr_ready_o;
    logic [135:0]      instr_i;
    logic [NB-1:0]     bank_rd_en_o;
    logic [NB*RL-1:0]  bank_raddr_o;
    logic [NB*DW-1:0]  bank_rdata_i;
    logic              op_valid_o;
    logic              op_ready_i;
    logic [7:0]        op_opcode_o;
    logic [31:0]       op_dst_o;
    logic [1:0]        op_src_cnt_o;
    logic [3*DW-1:0]   op_src_data_o;
    logic              err_illegal_op_o;
    logic              err_addr_o;

    vpu_operand_fetch #(.RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
        .bank_rd_en_o(bank_rd_en_o), .bank_raddr_o(bank_raddr_o), .bank_rdata_i(bank_rdata_i),
        .op_valid_o(op_valid_o), .op_ready_i(op_ready_i), .op_opcode_o(op_opcode_o),
        .op_dst_o(op_dst_o), .op_src_cnt_o(op_src_cnt_o), .op_src_data_o(op_src_data_o),
        .err_illegal_op_o(err_illegal_op_o), .err_addr_o(err_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]    opc;
        logic [31:0]   dst;
        logic [1:0]    cnt;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [3:0]  log_rd [0:31];
    logic [39:0] log_ra [0:31];
    logic        err_seen;

    function automatic logic [DW-1:0] row_data(input int b, input int r);
        logic [31:0]   w;
        logic [DW-1:0] d;
        w = {8'hC0 | 8'(b), 6'd0, 10'(r), 8'h5A};
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = w ^ 32'(i * 32'h0101_0000);
        return d;
    endfunction

    // Registered read; junk when idle so a mistimed capture shows up.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_rd_en_o[b]) bank_rdata_i[b*DW +: DW] <= row_data(b, int'(bank_raddr_o[b*RL +: RL]));
            else                 bank_rdata_i[b*DW +: DW] <= {16{32'hDEAD_BEEF}};
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] opc, input logic [31:0] dst, input logic [1:0] cnt,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        exp_t e;
        e.opc = opc; e.dst = dst; e.cnt = cnt; e.d0 = d0; e.d1 = d1; e.d2 = d2;
        sb_q.push_back(e);
    endtask

    // Called just after a rising edge; the instruction is accepted on the next rising edge.
    task automatic send(input logic [7:0] op, input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] dst);
        instr_valid_i = 1'b1;
        instr_i       = {op, 32'hFFFF_FFFF, s1, s0, dst};
        @(negedge clk);
        check("instr_ready", instr_ready_o, 1);
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        instr_i       = '0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        bit seen;
        n = 0; seen = 0; err_seen = 0;
        for (int i = 0; i < 32; i++) begin log_rd[i] = '0; log_ra[i] = '0; end
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(negedge clk);
            log_rd[i] = bank_rd_en_o;
            log_ra[i] = bank_raddr_o;
            err_seen  = err_seen | err_addr_o | err_illegal_op_o;
            if (op_valid_o) begin seen = 1; n = i; end
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_noerr"}, err_seen, 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && op_valid_o && op_ready_i) begin
            if (sb_q.size() == 0) check("unexpected_bundle", 1, 0);
            else begin
                mon_e = sb_q.pop_front();
                check("opcode", op_opcode_o, mon_e.opc);
                check("dst", op_dst_o, mon_e.dst);
                check("src_cnt", op_src_cnt_o, mon_e.cnt);
                check("slot0", op_src_data_o[0 +: DW], mon_e.d0);
                check("slot1", op_src_data_o[DW +: DW], mon_e.d1);
                check("slot2", op_src_data_o[2*DW +: DW], mon_e.d2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; instr_valid_i = 1'b0; instr_i = '0; op_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", instr_ready_o, 1);
        check("rst_valid", op_valid_o, 0);
        check("rst_rden", bank_rd_en_o, 0);
        check("rst_raddr", bank_raddr_o, 0);
        check("rst_opcode", op_opcode_o, 0);
        check("rst_slot0", op_src_data_o[0 +: DW], 0);
        check("rst_errs", {err_illegal_op_o, err_addr_o}, 0);
        @(posedge clk); #1;

        // FADD, banks 0 and 1
        push(8'h07, 32'h1234_5678, 2'd2, row_data(0, 0), row_data(1, 0), '0);
        send(8'h07, 32'h0000_0000, 32'h0000_0200, 32'h1234_5678);
        wait_valid("fadd", 3);
        check("fadd_rden1", log_rd[1], 4'b0011);
        check("fadd_rden2", log_rd[2], 4'b0000);

        // FMUL, bank 0 rows 1 and 2: serialized
        push(8'h09, 32'hCAFE_0001, 2'd2, row_data(0, 1), row_data(0, 2), '0);
        send(8'h09, 32'h0000_0800, 32'h0000_1000, 32'hCAFE_0001);
        wait_valid("fmul_conf", 5);
        check("conf_rden1", log_rd[1], 4'b0001);
        check("conf_ra1", log_ra[1][9:0], 10'd1);
        check("conf_rden2", log_rd[2], 4'b0000);
        check("conf_rden3", log_rd[3], 4'b0001);
        check("conf_ra3", log_ra[3][9:0], 10'd2);

        // FMUL, identical sources
        push(8'h09, 32'hCAFE_0002, 2'd2, row_data(0, 1), row_data(0, 1), '0);
        send(8'h09, 32'h0000_0800, 32'h0000_0800, 32'hCAFE_0002);
`ifdef VPU_OPFETCH_SAME_ADDR_MERGE_EN
        wait_valid("same", 3);
        check("same_rden3", log_rd[3], 4'b0000);
`else
        wait_valid("same", 5);
        check("same_rden3", log_rd[3], 4'b0001);
        check("same_ra3", log_ra[3][9:0], 10'd1);
`endif
        check("same_rden1", log_rd[1], 4'b0001);

        // FSQRT: one source, src1 out of range but unused
        push(8'h0C, 32'h0000_00AB, 2'd1, row_data(3, 0), '0, '0);
        send(8'h0C, 32'h0000_0600, 32'hFFFF_FFFF, 32'h0000_00AB);
        wait_valid("fsqrt", 3);
        check("fsqrt_rden1", log_rd[1], 4'b1000);

        // Highest legal address on bank 3, plus bank 2
        push(8'h0E, 32'h0BAD_F00D, 2'd2, row_data(3, 1023), row_data(2, 0), '0);
        send(8'h0E, 32'h001F_FE00, 32'h0000_0400, 32'h0BAD_F00D);
        wait_valid("maxaddr", 3);
        check("maxaddr_rden1", log_rd[1], 4'b1100);
        check("maxaddr_ra1", log_ra[1][39:30], 10'h3FF);

        // Illegal opcode 0x0F
        send(8'h0F, 32'h0000_0000, 32'h0000_0200, 32'h1);
        @(negedge clk);
        check("ill_pulse", err_illegal_op_o, 1);
        check("ill_noaddr", err_addr_o, 0);
        check("ill_rden", bank_rd_en_o, 0);
        check("ill_ready", instr_ready_o, 1);
        @(negedge clk);
        check("ill_pulse_end", err_illegal_op_o, 0);
        @(posedge clk); #1;

        // Opcode 0x00 with bad address: illegal opcode wins
        send(8'h00, 32'h0020_0000, 32'h0000_0200, 32'h2);
        @(negedge clk);
        check("prio_ill", err_illegal_op_o, 1);
        check("prio_noaddr", err_addr_o, 0);
        @(posedge clk); #1;

        // FADD with out-of-range src0
        send(8'h07, 32'h0020_0000, 32'h0000_0200, 32'h3);
        @(negedge clk);
        check("addr_pulse", err_addr_o, 1);
        check("addr_noill", err_illegal_op_o, 0);
        check("addr_rden", bank_rd_en_o, 0);
        check("addr_ready", instr_ready_o, 1);
        @(negedge clk);
        check("addr_pulse_end", err_addr_o, 0);
        @(posedge clk); #1;

        // FADD with out-of-range src1
        send(8'h07, 32'h0000_0000, 32'h8000_0000, 32'h4);
        @(negedge clk);
        check("addr1_pulse", err_addr_o, 1);
        @(posedge clk); #1;

        // Downstream stall
        op_ready_i = 1'b0;
        push(8'h07, 32'h5555_AAAA, 2'd2, row_data(2, 5), row_data(1, 7), '0);
        send(8'h07, 32'h0000_2C00, 32'h0000_3A00, 32'h5555_AAAA);
        wait_valid("stall", 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", op_valid_o, 1);
            check("stall_opcode", op_opcode_o, 8'h07);
            check("stall_slot0", op_src_data_o[0 +: DW], row_data(2, 5));
            check("stall_slot1", op_src_data_o[DW +: DW], row_data(1, 7));
            check("stall_ready", instr_ready_o, 0);
        end
        @(posedge clk); #1;
        op_ready_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_hs_valid", op_valid_o, 0);
        check("post_hs_slot0", op_src_data_o[0 +: DW], 0);
        @(posedge clk); #1;

        // Reset while waiting on read data
        send(8'h07, 32'h0000_0000, 32'h0000_0200, 32'h6);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", op_valid_o, 0);
        check("arst_ready", instr_ready_o, 1);
        check("arst_rden", bank_rd_en_o, 0);
        check("arst_raddr", bank_raddr_o, 0);
        check("arst_opcode", op_opcode_o, 0);
        check("arst_dst", op_dst_o, 0);
        check("arst_cnt", op_src_cnt_o, 0);
        check("arst_slot0", op_src_data_o[0 +: DW], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("arst_no_bundle", op_valid_o, 0);
            check("arst_no_read", bank_rd_en_o, 0);
        end

        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vpu_operand_fetch.md
Name: vpu_operand_fetch

Overview:
- Sits between the VPU request FIFO and the vector lanes.
- Pops one 136-bit instruction (opcode, src2, src1, src0, dst0), decodes each used source address into bank ID and row, and issues SRAM bank reads, serializing bank conflicts.
- Captures the returned 512-bit rows and presents one operand bundle (opcode, dst0, up to 3 source rows) downstream with valid/ready.

Parameters:
- SRAM_BANK_CNT, 4, number of SRAM banks (bank ID width 2).
- SRAM_BANK_DEPTH_LG2, 10, row address width.
- SRAM_DATA_WIDTH, 512, row width in bits.
- SRC_OPERAND_CNT, 3, source operand slots.
- RD_LAT, 1, SRAM read latency in cycles (1..4).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid_i  in  1  request FIFO has an instruction.
- instr_ready_o  out  1  block accepts an instruction.
- instr_i  in  136  {opcode[135:128], src2[127:96], src1[95:64], src0[63:32], dst0[31:0]}.
- bank_rd_en_o  out  4  per-bank read strobe.
- bank_raddr_o  out  40  per-bank row address, bank b at [10b+:10].
- bank_rdata_i  in  2048  per-bank read data, bank b at [512b+:512]; valid RD_LAT cycles after rd_en.
- op_valid_o  out  1  operand bundle valid.
- op_ready_i  in  1  lanes accept the bundle.
- op_opcode_o  out  8  opcode.
- op_dst_o  out  32  dst0 address, passed through unchanged.
- op_src_cnt_o  out  2  number of valid sources (1 or 2).
- op_src_data_o  out  1536  source s data at [512s+:512]; unused slots are 0.
- err_illegal_op_o  out  1  one-cycle pulse, illegal opcode dropped.
- err_addr_o  out  1  one-cycle pulse, out-of-range address dropped.

Behaviour:
- Decode:
  - bank = addr[10:9]; row = addr[20:11]; addr[31:21] must be 0.
  - Source count: opcodes 0x05 (ITF), 0x0C (FSQRT), 0x0D (FTI) use 1 source (src0).
  - Opcodes 0x01–0x04, 0x06–0x0B, 0x0E use 2 sources (src0, src1).
  - src2 is ignored in this revision.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - instr_ready_o=1; handshake on instr_valid_i & instr_ready_o.
  - Opcode outside the legal set: instruction dropped, err_illegal_op_o pulses next cycle, stay IDLE.
  - Any used source address with nonzero [31:21]: instruction dropped, err_addr_o pulses next cycle, stay IDLE. Illegal opcode takes priority.
  - Otherwise latch the instruction, set pending mask, go to ISSUE.
- ISSUE (one cycle):
  - For each bank, the lowest-index pending source mapped to it is issued: rd_en high, raddr = row.
  - Issued sources are cleared from pending. Load wait counter = RD_LAT, go to WAIT.
- WAIT:
  - Count down. On the cycle the counter reaches 1, capture bank_rdata_i into each issued source slot.
  - Then go to ISSUE if pending is nonzero, else OUT.
- OUT: op_valid_o=1 with stable payload until op_ready_i; on handshake clear payload and go to IDLE. instr_ready_o=0 in all non-IDLE states.
- Latency (no conflict, RD_LAT=1): accept at T, rd_en at T+1, capture at T+2, op_valid_o at T+3.
- Each serialized conflict adds 1+RD_LAT cycles.
- bank_rd_en_o is 0 outside ISSUE; bank_raddr_o holds its last value.
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs 0 except instr_ready_o, which is 1 after reset. In-flight reads and latched data are discarded.
- op_ready_i high outside OUT is ignored.

Optional Feature:
- Macro: VPU_OPFETCH_SAME_ADDR_MERGE_EN.
- Defined: pending sources with identical bank and row are issued as one read in the same ISSUE cycle, and all of them capture that data. Example: src0==src1 costs no extra round.
- Undefined: they are serialized like any other bank conflict.

Test Plan:
- FADD 0x07, src0=0x000, src1=0x200 (banks 0,1), RD_LAT=1, op_ready_i=1 -> rd_en=4'b0011 at T+1; op_valid at T+3 with data of bank0 row0 and bank1 row0; op_src_cnt=2.
- FMUL 0x09, src0=0x800, src1=0x1000 (both bank 0, rows 1,2) -> two ISSUE rounds, row 1 then row 2; op_valid at T+5.
- Same instruction with src0=src1=0x800 -> merge defined: one read, op_valid at T+3; undefined: op_valid at T+5.
- FSQRT 0x0C, src0=0x600 -> only bank 3 read, row 0; op_src_cnt=1; slots 1 and 2 are 0.
- Opcode 0x0F -> err_illegal_op pulse, no rd_en; src0=0x0020_0000 with FADD -> err_addr pulse; instr_ready_o stays 1 in both cases.
- op_ready_i held 0 for 5 cycles in OUT, then rst_n low mid-WAIT on the next instruction -> payload stable while stalled; after reset all outputs 0, instr_ready_o=1, no bundle emitted.
